// File: rtl/poets_mem_pkg.sv
// Shared types and constants for the POETS message-memory stream writer.
package poets_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    HEADER
  } state_t;

  localparam int HDR_TRUNC_BIT = 31;
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_W     = 16;
  localparam int MEM_DATA_W    = 32;
  localparam int MEM_BE_W      = 4;

endpackage

// File: rtl/poets_slot_counter.sv
// Ring occupancy counter and write-slot pointer for the message-memory writer.
module poets_slot_counter #(
  parameter int NUM_SLOTS = 64,
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1),
  parameter int PTR_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             commit,
  input  logic             release_slot,
  output logic [CNT_W-1:0] slots_used,
  output logic [PTR_W-1:0] wr_slot
);

  logic rel_ok;

  // A release against an empty ring has nothing to free.
  assign rel_ok = release_slot && (slots_used != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slots_used <= '0;
      wr_slot    <= '0;
    end else begin
      if (commit) wr_slot <= wr_slot + PTR_W'(1);
      if (commit && !rel_ok)      slots_used <= slots_used + CNT_W'(1);
      else if (!commit && rel_ok) slots_used <= slots_used - CNT_W'(1);
    end
  end

endmodule

// File: rtl/poets_mem_stream_writer.sv
// Avalon-ST packet sink writing packets into a slot ring, header word last.
// Optional drop-when-full mode: define POETS_MEM_WRITER_DROP_EN.
module poets_mem_stream_writer
  import poets_mem_pkg::*;
#(
  parameter int BASE_ADDR  = 0,
  parameter int SLOT_WORDS = 16,
  parameter int NUM_SLOTS  = 64,
  parameter int ADDR_W     = 14
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   snk_data,
  input  logic                          snk_valid,
  output logic                          snk_ready,
  input  logic                          snk_sop,
  input  logic                          snk_eop,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [3:0]                    mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [31:0]                   mem_writedata,
  output logic                          mem_clken,
  input  logic                          release_slot,
  output logic [$clog2(NUM_SLOTS+1)-1:0] slots_used,
  output logic [$clog2(NUM_SLOTS)-1:0]  wr_slot,
  output logic                          pkt_done
`ifdef POETS_MEM_WRITER_DROP_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  localparam int OFF_W = $clog2(SLOT_WORDS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int PTR_W = $clog2(NUM_SLOTS);
`ifdef POETS_MEM_WRITER_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  state_t                  state, state_nx;
  logic [OFF_W-1:0]        idx, idx_nx;
  logic                    trunc, trunc_nx;
  logic                    drop, drop_nx;
  logic                    full;
  logic                    commit;
  logic                    wr_en;
  logic [OFF_W-1:0]        wr_off;
  logic [MEM_DATA_W-1:0]   wr_data;
  logic [MEM_DATA_W-1:0]   hdr;

  assign full = (slots_used == CNT_W'(NUM_SLOTS));

  poets_slot_counter #(
    .NUM_SLOTS (NUM_SLOTS),
    .CNT_W     (CNT_W),
    .PTR_W     (PTR_W)
  ) u_slot_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .commit       (commit),
    .release_slot (release_slot),
    .slots_used   (slots_used),
    .wr_slot      (wr_slot)
  );

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    trunc_nx  = trunc;
    drop_nx   = drop;
    snk_ready = 1'b0;
    wr_en     = 1'b0;
    wr_off    = '0;
    wr_data   = snk_data;
    commit    = 1'b0;
    hdr       = '0;
    hdr[HDR_TRUNC_BIT]               = trunc;
    hdr[HDR_LEN_LSB +: HDR_LEN_W]    = HDR_LEN_W'(idx);
    unique case (state)
      IDLE: begin
        // mem_clken doubles as the "out of reset" flag gating readiness.
        snk_ready = mem_clken && (!full || DROP_EN);
        if (snk_valid && snk_ready && snk_sop) begin
          idx_nx   = OFF_W'(1);
          trunc_nx = 1'b0;
          if (DROP_EN && full) begin
            drop_nx = !snk_eop;
            if (!snk_eop) state_nx = PAYLOAD;
          end else begin
            wr_en    = 1'b1;
            wr_off   = OFF_W'(1);
            state_nx = snk_eop ? HEADER : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        snk_ready = 1'b1;
        if (snk_valid) begin
          if (!drop) begin
            if (idx < OFF_W'(SLOT_WORDS - 1)) begin
              wr_en  = 1'b1;
              wr_off = idx + OFF_W'(1);
              idx_nx = idx + OFF_W'(1);
            end else begin
              trunc_nx = 1'b1;
            end
          end
          if (snk_eop) begin
            state_nx = drop ? IDLE : HEADER;
            drop_nx  = 1'b0;
          end
        end
      end
      HEADER: begin
        wr_en    = 1'b1;
        wr_off   = '0;
        wr_data  = hdr;
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      trunc <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      trunc <= trunc_nx;
      drop  <= drop_nx;
    end
  end

  // Registered write port: a decision made this cycle appears on the bus next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_clken      <= 1'b0;
      pkt_done       <= 1'b0;
    end else begin
      mem_address    <= ADDR_W'(BASE_ADDR + int'(wr_slot) * SLOT_WORDS + int'(wr_off));
      mem_byteenable <= wr_en ? {MEM_BE_W{1'b1}} : '0;
      mem_chipselect <= wr_en;
      mem_write      <= wr_en;
      mem_writedata  <= wr_data;
      mem_clken      <= 1'b1;
      pkt_done       <= commit;
    end
  end

`ifdef POETS_MEM_WRITER_DROP_EN
  logic drop_end;

  assign drop_end = snk_valid && snk_ready && snk_eop &&
                    ((state == IDLE && snk_sop && full) || (state == PAYLOAD && drop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          drop_count <= '0;
    else if (drop_end && drop_count != '1) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_poets_mem_stream_writer.sv
// Directed self-checking bench for poets_mem_stream_writer (default parameters).
module tb_poets_mem_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic        snk_sop = 1'b0;
  logic        snk_eop = 1'b0;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        release_slot = 1'b0;
  logic [6:0]  slots_used;
  logic [5:0]  wr_slot;
  logic        pkt_done;
`ifdef POETS_MEM_WRITER_DROP_EN
  logic [15:0] drop_count;
`endif

  poets_mem_stream_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .release_slot   (release_slot),
    .slots_used     (slots_used),
    .wr_slot        (wr_slot),
    .pkt_done       (pkt_done)
`ifdef POETS_MEM_WRITER_DROP_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        cs;
    logic        pd;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  pd_cnt = 0;
  int  rd = 0;
  int  checks = 0;
  int  errors = 0;
  int  acc_cyc = 0;
  int  nacc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (mem_write) begin
      w.a = mem_address; w.d = mem_writedata; w.be = mem_byteenable;
      w.cs = mem_chipselect; w.pd = pkt_done; w.c = cyc;
      wq.push_back(w);
    end
    if (pkt_done) pd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    int n;
    n = 0;
    snk_data = d; snk_sop = s; snk_eop = e; snk_valid = 1'b1;
    while (!snk_ready && n < 100) begin tick(1); n++; end
    if (n >= 100) check("send_timeout", 32'(snk_ready), 32'd1);
    else nacc++;
    acc_cyc = cyc;
    @(posedge clk);
    tick(1);
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int a, input logic [31:0] d,
                              input logic pd, output int c);
    wr_t w;
    c = -1;
    checks++;
    assert (rd < wq.size()) else begin
      errors++;
      $error("FAIL %s_present got %0d writes expected at least %0d", tag, wq.size(), rd + 1);
    end
    if (rd < wq.size()) begin
      w = wq[rd];
      rd++;
      check({tag, "_addr"}, 32'(w.a), 32'(a));
      check({tag, "_data"}, w.d, d);
      check({tag, "_pd"}, 32'(w.pd), 32'(pd));
      check({tag, "_be_cs"}, {27'd0, w.cs, w.be}, 32'h1F);
      c = w.c;
    end
  endtask

  task automatic flush();
    rd = wq.size();
  endtask

  initial begin
    int c, ch, pd0;

    // Reset state
    tick(2);
    check("rst_ready", 32'(snk_ready), 0);
    check("rst_clken", 32'(mem_clken), 0);
    check("rst_write", 32'(mem_write), 0);
    check("rst_cs", 32'(mem_chipselect), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_used", 32'(slots_used), 0);
    check("rst_slot", 32'(wr_slot), 0);
    check("rst_pd", 32'(pkt_done), 0);
    reset_n = 1'b1;
    tick(1);
    check("clken_up", 32'(mem_clken), 1);

    // 3-word packet into slot 0
    send(32'hAAAA_0001, 1, 0);
    send(32'hBBBB_0002, 0, 0);
    send(32'hCCCC_0003, 0, 1);
    tick(3);
    expect_write("p3_a", 1, 32'hAAAA_0001, 0, c);
    expect_write("p3_b", 2, 32'hBBBB_0002, 0, c);
    expect_write("p3_c", 3, 32'hCCCC_0003, 0, c);
    check("p3_lat_last", 32'(c), 32'(acc_cyc + 1));
    expect_write("p3_hdr", 0, 32'h0000_0003, 1, ch);
    check("p3_lat_hdr", 32'(ch), 32'(acc_cyc + 2));
    check("p3_used", 32'(slots_used), 1);
    check("p3_slot", 32'(wr_slot), 1);

    // Single-beat packet into slot 5
    for (int i = 1; i < 5; i++) send(32'(i), 1, 1);
    tick(3);
    flush();
    send(32'hDEAD_BEEF, 1, 1);
    check("p1_ready_low", 32'(snk_ready), 0);
    tick(1);
    check("p1_ready_back", 32'(snk_ready), 1);
    tick(2);
    expect_write("p1_pay", 81, 32'hDEAD_BEEF, 0, c);
    expect_write("p1_hdr", 80, 32'h0000_0001, 1, c);
    check("p1_used", 32'(slots_used), 6);

    // 20-beat packet truncated to 15 payload words, slot 6
    nacc = 0;
    for (int i = 0; i < 20; i++) send(32'h100 + 32'(i), i == 0, i == 19);
    tick(3);
    check("p20_accepted", 32'(nacc), 20);
    for (int i = 0; i < 15; i++) expect_write("p20_pay", 97 + i, 32'h100 + 32'(i), 0, c);
    expect_write("p20_hdr", 96, 32'h8000_000F, 1, c);
    check("p20_extra", 32'(wq.size() - rd), 0);
    check("p20_used", 32'(slots_used), 7);

    // Release coinciding with commit
    send(32'h77, 1, 1);
    release_slot = 1'b1;
    tick(1);
    release_slot = 1'b0;
    check("relc_used", 32'(slots_used), 7);
    check("relc_slot", 32'(wr_slot), 8);
    tick(2);
    flush();

    // Reset mid-packet after two payload writes
    send(32'hA0, 1, 0);
    send(32'hA1, 0, 0);
    check("mid_writes", 32'(wq.size() - rd), 2);
    pd0 = pd_cnt;
    reset_n = 1'b0;
    #1;
    check("mid_write", 32'(mem_write), 0);
    check("mid_cs", 32'(mem_chipselect), 0);
    check("mid_addr", 32'(mem_address), 0);
    check("mid_data", mem_writedata, 0);
    check("mid_be", 32'(mem_byteenable), 0);
    check("mid_used", 32'(slots_used), 0);
    check("mid_slot", 32'(wr_slot), 0);
    check("mid_ready", 32'(snk_ready), 0);
    check("mid_pd", 32'(pkt_done), 0);
    check("mid_clken", 32'(mem_clken), 0);
    flush();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("mid_no_hdr", 32'(wq.size() - rd), 0);
    check("mid_no_pd", 32'(pd_cnt), 32'(pd0));
    release_slot = 1'b1;
    tick(1);
    release_slot = 1'b0;
    check("rel0_used", 32'(slots_used), 0);
    send(32'hB0, 1, 1);
    tick(3);
    expect_write("post_pay", 1, 32'hB0, 0, c);
    expect_write("post_hdr", 0, 32'h0000_0001, 1, c);

    // Fill the ring
    for (int i = 1; i < 64; i++) send(32'h1000 + 32'(i), 1, 1);
    tick(3);
    flush();
    check("full_used", 32'(slots_used), 64);
    check("full_slot", 32'(wr_slot), 0);
`ifdef POETS_MEM_WRITER_DROP_EN
    pd0 = pd_cnt;
    for (int i = 0; i < 4; i++) send(32'hD0 + 32'(i), i == 0, i == 3);
    tick(3);
    check("drop_writes", 32'(wq.size() - rd), 0);
    check("drop_count", 32'(drop_count), 1);
    check("drop_pd", 32'(pd_cnt), 32'(pd0));
    check("drop_used", 32'(slots_used), 64);
`else
    snk_data = 32'hEE; snk_sop = 1'b1; snk_eop = 1'b1; snk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("bp_ready", 32'(snk_ready), 0);
    end
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    tick(2);
    check("bp_writes", 32'(wq.size() - rd), 0);
`endif
    release_slot = 1'b1;
    tick(1);
    release_slot = 1'b0;
    check("wrap_used", 32'(slots_used), 63);
    check("wrap_ready", 32'(snk_ready), 1);
    send(32'hC0, 1, 1);
    tick(3);
    expect_write("wrap_pay", 1, 32'hC0, 0, c);
    expect_write("wrap_hdr", 0, 32'h0000_0001, 1, c);
    check("wrap_used2", 32'(slots_used), 64);
    check("wrap_slot", 32'(wr_slot), 1);
    check("pd_total", 32'(pd_cnt), 73);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
